calendar_clock: RTL and testbench

CALENDAR_CLOCK -- requirements
Module: calendar_clock

---
 rtl/calendar_pkg.sv | 71 +++++++
 rtl/calendar_clock_bcd_wrap_counter.sv | 58 +++++
 rtl/calendar_clock.sv | 162 ++++++++++++++++
 tb/tb_calendar_clock.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calendar_pkg.sv
// Shared definitions for the BCD calendar clock: field select codes,
// per-field limits and BCD/calendar helper functions.
package calendar_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [2:0] {
        SEL_CENTISECOND = 3'd0,
        SEL_SECOND      = 3'd1,
        SEL_MINUTE      = 3'd2,
        SEL_HOUR        = 3'd3,
        SEL_DAY         = 3'd4,
        SEL_MONTH       = 3'd5,
        SEL_YEAR        = 3'd6,
        SEL_NONE        = 3'd7
    } sel_e;

    localparam logic [7:0] CS_MIN        = 8'h00;
    localparam logic [7:0] CS_MAX        = 8'h99;
    localparam logic [6:0] SEC_MIN       = 7'h00;
    localparam logic [6:0] SEC_MAX       = 7'h59;
    localparam logic [6:0] MINUTE_MIN    = 7'h00;
    localparam logic [6:0] MINUTE_MAX    = 7'h59;
    localparam logic [5:0] HOUR_MIN      = 6'h00;
    localparam logic [5:0] HOUR_MAX      = 6'h23;
    localparam logic [5:0] DAY_MIN       = 6'h01;
    localparam logic [5:0] DAY_MAX       = 6'h31;
    localparam logic [4:0] MONTH_MIN     = 5'h01;
    localparam logic [4:0] MONTH_MAX     = 5'h12;
    localparam logic [7:0] YEAR_PAIR_MIN = 8'h00;
    localparam logic [7:0] YEAR_PAIR_MAX = 8'h99;

    // Two-digit BCD increment, 99 wraps to 00.
    function automatic logic [7:0] bcd_pair_inc(input logic [7:0] v);
        logic [3:0] ones;
        logic [3:0] tens;
        ones = v[3:0];
        tens = v[7:4];
        if (ones == 4'd9) begin
            bcd_pair_inc = (tens == 4'd9) ? 8'h00 : {tens + 4'd1, 4'd0};
        end else begin
            bcd_pair_inc = {tens, ones + 4'd1};
        end
    endfunction

    // True when a two-digit BCD value is a multiple of four.
    function automatic logic bcd_div4(input logic [7:0] v);
        logic [7:0] bin;
        bin = 8'(v[7:4]) * 8'd10 + 8'(v[3:0]);
        bcd_div4 = ((bin % 8'd4) == 8'd0);
    endfunction

    // Gregorian leap rule evaluated directly on the four BCD year digits.
    function automatic logic is_leap(input logic [15:0] y);
        if (y[7:0] == 8'h00) begin
            is_leap = bcd_div4(y[15:8]);
        end else begin
            is_leap = bcd_div4(y[7:0]);
        end
    endfunction

    // Days in a BCD month for a BCD year.
    function automatic logic [5:0] days_in_month(input logic [4:0] m, input logic [15:0] y);
        case (m)
            5'h04, 5'h06, 5'h09, 5'h11: days_in_month = 6'h30;
            5'h02:                      days_in_month = is_leap(y) ? 6'h29 : 6'h28;
            default:                    days_in_month = 6'h31;
        endcase
    endfunction

endpackage

// File: rtl/calendar_clock_bcd_wrap_counter.sv
// Two-digit BCD counter with a wrap range, clear-to-minimum, arbitrary load
// and an optional run-time maximum (used by the day field).
module bcd_wrap_counter
    import calendar_pkg::*;
#(
    parameter int         W   = 8,
    parameter logic [W-1:0] MIN = '0,
    parameter logic [W-1:0] MAX = '0,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         load_min,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         max_override,
    input  logic [W-1:0] max_value,
    output logic [W-1:0] value,
    output logic         wrap
);

    logic [DIGIT_W-1:0]   ones;
    logic [W-DIGIT_W-1:0] tens;
    logic [W-1:0]         max_eff;
    logic [W-1:0]         value_inc;
    logic                 at_max;

    // Next-count and wrap decode; every output gets a default first.
    // NOTE: defaults at the top of always_comb keep it free of inferred latches.
    always_comb begin
        ones    = value[DIGIT_W-1:0];
        tens    = value[W-1:DIGIT_W];
        max_eff = max_override ? max_value : MAX;
        at_max  = (value >= max_eff);
        if (ones == 4'd9) begin
            value_inc = {tens + 1'b1, {DIGIT_W{1'b0}}};
        end else begin
            value_inc = {tens, ones + 4'd1};
        end
        wrap = inc & at_max;
    end

    // Count register: clear beats load beats increment.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= RST;
        end else if (load_min) begin
            value <= MIN;
        end else if (load) begin
            value <= load_value;
        end else if (inc) begin
            value <= at_max ? MIN : value_inc;
        end
    end

endmodule

// File: rtl/calendar_clock.sv
// BCD calendar clock: 10 ms prescaler, single-edge cascaded rollover of all
// fields, and a set mode that edits one field at a time from two buttons.
module calendar_clock
    import calendar_pkg::*;
#(
    parameter int          TICK_DIV  = 500000,
    parameter logic [15:0] YEAR_INIT = 16'h2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adjust,
    input  logic [2:0]  select,
    input  logic        add,
    input  logic        clr,
    output logic [7:0]  centisecond,
    output logic [6:0]  second,
    output logic [6:0]  minute,
    output logic [5:0]  hour,
    output logic [5:0]  day,
    output logic [4:0]  month,
    output logic [15:0] year,
    output logic        day_carry
);

    logic [23:0] prescaler;
    logic        tick;
    logic        add_q, clr_q, add_armed, clr_armed;
    logic        add_rise, clr_rise, set_active, add_ev, clr_ev;
    logic        cs_wrap, sec_wrap, min_wrap, hour_wrap, day_wrap, month_wrap;
    logic        year_lo_wrap, year_hi_wrap_unused;
    logic        mon_chg, yr_chg, day_clamp;
    logic [4:0]  month_inc, month_new, month_eff;
    logic [15:0] year_new, year_eff;
    logic [5:0]  dim_now, dim_next;

    // Time base: counts only in run mode, parked at zero while adjusting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (adjust || prescaler == 24'(TICK_DIV - 1)) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 24'd1;
        end
    end

    assign tick = !adjust && (prescaler == 24'(TICK_DIV - 1));

    // Button edge detect; a button must be seen low once after reset before
    // its rising edge counts, so a press held through reset does nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_q     <= 1'b0;
            clr_q     <= 1'b0;
            add_armed <= 1'b0;
            clr_armed <= 1'b0;
        end else begin
            add_q     <= add;
            clr_q     <= clr;
            add_armed <= add_armed | ~add;
            clr_armed <= clr_armed | ~clr;
        end
    end

    assign add_rise   = add & ~add_q & add_armed;
    assign clr_rise   = clr & ~clr_q & clr_armed;
    assign set_active = adjust && (select != SEL_NONE);
    assign clr_ev     = set_active & clr_rise;
    assign add_ev     = set_active & add_rise & ~clr_rise;

    // Preview of month/year after a set-mode edit, to clamp day on the same edge.
    always_comb begin
        month_inc = (month[3:0] == 4'd9) ? 5'h10 : {month[4], month[3:0] + 4'd1};
        month_new = (clr_ev || month >= MONTH_MAX) ? MONTH_MIN : month_inc;
        year_new  = clr_ev ? 16'h0000
                  : {(year[7:0] == YEAR_PAIR_MAX) ? bcd_pair_inc(year[15:8]) : year[15:8],
                     bcd_pair_inc(year[7:0])};
        mon_chg   = (add_ev | clr_ev) && (select == SEL_MONTH);
        yr_chg    = (add_ev | clr_ev) && (select == SEL_YEAR);
        month_eff = mon_chg ? month_new : month;
        year_eff  = yr_chg ? year_new : year;
        dim_now   = days_in_month(month, year);
        dim_next  = days_in_month(month_eff, year_eff);
        day_clamp = (mon_chg | yr_chg) && (day > dim_next);
    end

    // Run-mode rollover out of the last day of the month, one cycle wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_carry <= 1'b0;
        end else begin
            day_carry <= tick & day_wrap;
        end
    end

    bcd_wrap_counter #(.W(8), .MIN(CS_MIN), .MAX(CS_MAX), .RST(CS_MIN)) u_centisecond (
        .clk(clk), .rst_n(rst_n),
        .inc(tick | (add_ev && select == SEL_CENTISECOND)),
        .load_min(clr_ev && select == SEL_CENTISECOND),
        .load(1'b0), .load_value(8'h00), .max_override(1'b0), .max_value(8'h00),
        .value(centisecond), .wrap(cs_wrap)
    );

    bcd_wrap_counter #(.W(7), .MIN(SEC_MIN), .MAX(SEC_MAX), .RST(SEC_MIN)) u_second (
        .clk(clk), .rst_n(rst_n),
        .inc((tick & cs_wrap) | (add_ev && select == SEL_SECOND)),
        .load_min(clr_ev && select == SEL_SECOND),
        .load(1'b0), .load_value(7'h00), .max_override(1'b0), .max_value(7'h00),
        .value(second), .wrap(sec_wrap)
    );

    bcd_wrap_counter #(.W(7), .MIN(MINUTE_MIN), .MAX(MINUTE_MAX), .RST(MINUTE_MIN)) u_minute (
        .clk(clk), .rst_n(rst_n),
        .inc((tick & sec_wrap) | (add_ev && select == SEL_MINUTE)),
        .load_min(clr_ev && select == SEL_MINUTE),
        .load(1'b0), .load_value(7'h00), .max_override(1'b0), .max_value(7'h00),
        .value(minute), .wrap(min_wrap)
    );

    bcd_wrap_counter #(.W(6), .MIN(HOUR_MIN), .MAX(HOUR_MAX), .RST(HOUR_MIN)) u_hour (
        .clk(clk), .rst_n(rst_n),
        .inc((tick & min_wrap) | (add_ev && select == SEL_HOUR)),
        .load_min(clr_ev && select == SEL_HOUR),
        .load(1'b0), .load_value(6'h00), .max_override(1'b0), .max_value(6'h00),
        .value(hour), .wrap(hour_wrap)
    );

    // Day wraps at the current month length and is clamped after month/year edits.
    bcd_wrap_counter #(.W(6), .MIN(DAY_MIN), .MAX(DAY_MAX), .RST(DAY_MIN)) u_day (
        .clk(clk), .rst_n(rst_n),
        .inc((tick & hour_wrap) | (add_ev && select == SEL_DAY)),
        .load_min(clr_ev && select == SEL_DAY),
        .load(day_clamp), .load_value(dim_next), .max_override(1'b1), .max_value(dim_now),
        .value(day), .wrap(day_wrap)
    );

    bcd_wrap_counter #(.W(5), .MIN(MONTH_MIN), .MAX(MONTH_MAX), .RST(MONTH_MIN)) u_month (
        .clk(clk), .rst_n(rst_n),
        .inc((tick & day_wrap) | (add_ev && select == SEL_MONTH)),
        .load_min(clr_ev && select == SEL_MONTH),
        .load(1'b0), .load_value(5'h00), .max_override(1'b0), .max_value(5'h00),
        .value(month), .wrap(month_wrap)
    );

    // Year is two cascaded pairs; the high pair follows the low pair in both modes.
    bcd_wrap_counter #(.W(8), .MIN(YEAR_PAIR_MIN), .MAX(YEAR_PAIR_MAX), .RST(YEAR_INIT[7:0])) u_year_lo (
        .clk(clk), .rst_n(rst_n),
        .inc((tick & month_wrap) | (add_ev && select == SEL_YEAR)),
        .load_min(clr_ev && select == SEL_YEAR),
        .load(1'b0), .load_value(8'h00), .max_override(1'b0), .max_value(8'h00),
        .value(year[7:0]), .wrap(year_lo_wrap)
    );

    bcd_wrap_counter #(.W(8), .MIN(YEAR_PAIR_MIN), .MAX(YEAR_PAIR_MAX), .RST(YEAR_INIT[15:8])) u_year_hi (
        .clk(clk), .rst_n(rst_n),
        .inc(year_lo_wrap),
        .load_min(clr_ev && select == SEL_YEAR),
        .load(1'b0), .load_value(8'h00), .max_override(1'b0), .max_value(8'h00),
        .value(year[15:8]), .wrap(year_hi_wrap_unused)
    );

endmodule

// File: tb/tb_calendar_clock.sv
// Bench for calendar_clock with a fast time base: fields are preset through
// set mode, then rollovers and set-mode edits are scored against a queue.
module tb_calendar_clock;
    import calendar_pkg::*;

    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        adjust = 1'b0;
    logic [2:0]  select = 3'd7;
    logic        add = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  centisecond;
    logic [6:0]  second;
    logic [6:0]  minute;
    logic [5:0]  hour;
    logic [5:0]  day;
    logic [4:0]  month;
    logic [15:0] year;
    logic        day_carry;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } sb_t;
    sb_t sb_q[$];

    calendar_clock #(.TICK_DIV(TICK_DIV), .YEAR_INIT(16'h2000)) dut (
        .clk(clk), .rst_n(rst_n), .adjust(adjust), .select(select),
        .add(add), .clr(clr),
        .centisecond(centisecond), .second(second), .minute(minute),
        .hour(hour), .day(day), .month(month), .year(year),
        .day_carry(day_carry)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] b2(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [63:0] cal(input int y, input int mo, input int d,
                                        input int h, input int mi, input int s, input int cs);
        logic [7:0] yh, yl, mob, db, hb, mib, sb, csb;
        yh  = b2(y / 100);
        yl  = b2(y % 100);
        mob = b2(mo);
        db  = b2(d);
        hb  = b2(h);
        mib = b2(mi);
        sb  = b2(s);
        csb = b2(cs);
        return {9'd0, yh, yl, mob[4:0], db[5:0], hb[5:0], mib[6:0], sb[6:0], csb};
    endfunction

    function automatic logic [63:0] snap();
        return {9'd0, year, month, day, hour, minute, second, centisecond};
    endfunction

    task automatic sb_push(input string tag, input logic [63:0] val);
        sb_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [63:0] act);
        sb_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, act, e.val);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_add();
        add = 1'b1;
        cyc(1);
        add = 1'b0;
        cyc(1);
    endtask

    task automatic press_clr();
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(1);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        adjust = 1'b0;
        add    = 1'b0;
        clr    = 1'b0;
        select = SEL_NONE;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic set_adds(input logic [2:0] sel, input int n);
        select = sel;
        repeat (n) press_add();
    endtask

    // Reset, then build the target date/time with add presses in set mode.
    task automatic preset(input int y, input int mo, input int d,
                          input int h, input int mi, input int s, input int cs);
        do_reset();
        adjust = 1'b1;
        cyc(1);
        set_adds(SEL_YEAR, y - 2000);
        set_adds(SEL_MONTH, mo - 1);
        set_adds(SEL_DAY, d - 1);
        set_adds(SEL_HOUR, h);
        set_adds(SEL_MINUTE, mi);
        set_adds(SEL_SECOND, s);
        set_adds(SEL_CENTISECOND, cs);
        select = SEL_NONE;
        cyc(1);
        sb_push("preset", cal(y, mo, d, h, mi, s, cs));
        sb_pop_check(snap());
    endtask

    // Release adjust, wait (bounded) for the first tick, score it and the carry pulse.
    task automatic run_tick(input string tag, input logic [63:0] after, input logic exp_carry);
        logic [63:0] start;
        int          n;
        bit          seen;
        start = snap();
        n     = 0;
        seen  = 1'b0;
        sb_push(tag, after);
        adjust = 1'b0;
        while (n < 12 && !seen) begin
            cyc(1);
            n++;
            if (snap() !== start) seen = 1'b1;
        end
        check({tag, ".latency"}, 64'(n), 64'(TICK_DIV));
        sb_pop_check(snap());
        check({tag, ".carry"}, 64'(day_carry), 64'(exp_carry));
        adjust = 1'b1;
        cyc(1);
        check({tag, ".carry_end"}, 64'(day_carry), 64'd0);
        sb_push({tag, ".frozen"}, after);
        sb_pop_check(snap());
    endtask

    initial begin
        // Reset values while rst_n is low.
        cyc(2);
        sb_push("reset_hold", cal(2000, 1, 1, 0, 0, 0, 0));
        sb_pop_check(snap());
        check("reset_carry", 64'(day_carry), 64'd0);
        rst_n = 1'b1;
        cyc(1);

        // Year rollover from New Year's Eve.
        preset(2023, 12, 31, 23, 59, 59, 99);
        run_tick("new_year", cal(2024, 1, 1, 0, 0, 0, 0), 1'b1);

        // February ends for leap and non-leap years, including centuries.
        preset(2024, 2, 28, 23, 59, 59, 99);
        run_tick("feb_2024", cal(2024, 2, 29, 0, 0, 0, 0), 1'b0);
        preset(2023, 2, 28, 23, 59, 59, 99);
        run_tick("feb_2023", cal(2023, 3, 1, 0, 0, 0, 0), 1'b1);
        preset(2100, 2, 28, 23, 59, 59, 99);
        run_tick("feb_2100", cal(2100, 3, 1, 0, 0, 0, 0), 1'b1);
        preset(2000, 2, 28, 23, 59, 59, 99);
        run_tick("feb_2000", cal(2000, 2, 29, 0, 0, 0, 0), 1'b0);

        // Hour wraps in set mode without touching day; held add acts once.
        preset(2000, 1, 1, 23, 0, 0, 0);
        select = SEL_HOUR;
        sb_push("hour_wrap", cal(2000, 1, 1, 0, 0, 0, 0));
        press_add();
        sb_pop_check(snap());
        sb_push("hour_held", cal(2000, 1, 1, 1, 0, 0, 0));
        add = 1'b1;
        cyc(100);
        add = 1'b0;
        cyc(1);
        sb_pop_check(snap());

        // Edits ignored with select=none and in run mode.
        select = SEL_NONE;
        sb_push("sel_none", cal(2000, 1, 1, 1, 0, 0, 0));
        press_add();
        sb_pop_check(snap());
        select = SEL_HOUR;
        adjust = 1'b0;
        sb_push("run_ignore", cal(2000, 1, 1, 1, 0, 0, 0));
        press_add();
        adjust = 1'b1;
        cyc(1);
        sb_pop_check(snap());

        // Month and year edits clamp day to the new month length.
        preset(2024, 3, 31, 0, 0, 0, 0);
        select = SEL_MONTH;
        sb_push("month_clamp", cal(2024, 4, 30, 0, 0, 0, 0));
        press_add();
        sb_pop_check(snap());
        preset(2024, 2, 29, 0, 0, 0, 0);
        select = SEL_YEAR;
        sb_push("year_clamp", cal(2025, 2, 28, 0, 0, 0, 0));
        press_add();
        sb_pop_check(snap());
        select = SEL_DAY;
        sb_push("day_clr", cal(2025, 2, 1, 0, 0, 0, 0));
        press_clr();
        sb_pop_check(snap());

        // Simultaneous add and clr: clear wins.
        preset(2000, 1, 1, 0, 37, 0, 0);
        select = SEL_MINUTE;
        sb_push("clr_prio", cal(2000, 1, 1, 0, 0, 0, 0));
        add = 1'b1;
        clr = 1'b1;
        cyc(1);
        add = 1'b0;
        clr = 1'b0;
        cyc(1);
        sb_pop_check(snap());

        // Add held through reset is not an edge until released.
        add   = 1'b1;
        rst_n = 1'b0;
        cyc(2);
        rst_n  = 1'b1;
        adjust = 1'b1;
        select = SEL_CENTISECOND;
        cyc(5);
        sb_push("held_thru_reset", cal(2000, 1, 1, 0, 0, 0, 0));
        sb_pop_check(snap());
        add = 1'b0;
        cyc(1);
        sb_push("after_release", cal(2000, 1, 1, 0, 0, 0, 1));
        press_add();
        sb_pop_check(snap());

        // Asynchronous reset mid-count takes effect immediately.
        preset(2024, 5, 6, 7, 8, 9, 10);
        adjust = 1'b0;
        cyc(6);
        sb_push("run_mid", cal(2024, 5, 6, 7, 8, 9, 11));
        sb_pop_check(snap());
        #2;
        rst_n = 1'b0;
        #1;
        sb_push("async_reset", cal(2000, 1, 1, 0, 0, 0, 0));
        sb_pop_check(snap());
        check("async_reset_carry", 64'(day_carry), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
